id_rf_pipe: RTL and testbench
=============================

# id_rf_pipe

Parametrised decode/register-fetch stage for the pipelined core. It holds the register bank, write-back result mux, PC-copy register and constant extender, and registers operands A, B and the extended constant into an ID/EX pipeline register with valid, stall and flush control. Optional write-to-read bypass removes the one-cycle write-back hazard. It sits between instruction decode and the ULA/EX stage.

## Interface
- LARGURA, 16, data/register width
- NUM_REG, 8, number of registers (power of two, ≥2); AW = $clog2(NUM_REG)
- LARGURA_CONST, 12, raw constant width (≤ LARGURA)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valido  in  1  decode slot holds a valid instruction
- stall  in  1  downstream not ready; hold pipeline register
- flush  in  1  squash pipeline register
- hab_escrita  in  1  register-bank write enable
- sel_escrita  in  AW  write address
- sel_a, sel_b  in  AW  read addresses
- controle_resu  in  2  write-back source: 0 ULA, 1 MD, 2 copia_pc, 3 none
- entrada_ula, entrada_md  in  LARGURA  write-back data
- pc  in  LARGURA  current PC
- controle_pc_copia  in  1  capture pc into copia_pc
- ex_controle  in  3  extender mode
- ex_constante  in  LARGURA_CONST  raw constant
- a, b, constante_extendida  out  LARGURA  registered operands
- out_valido  out  1  registered operands valid
- copia_pc  out  LARGURA  saved PC (link value)

## Operation
- Register bank: NUM_REG × LARGURA, two asynchronous read ports, one write port. Write occurs at rising edge when hab_escrita=1 and controle_resu≠3; controle_resu=3 suppresses the write regardless of hab_escrita.
- Write data = mux(controle_resu) of entrada_ula / entrada_md / copia_pc.
- copia_pc loads pc at rising edge when controle_pc_copia=1, otherwise holds. A same-cycle write-back selecting copia_pc writes the old copia_pc.
- Extender (ex_controle): 000 zero-extend; 001 sign-extend from bit LARGURA_CONST-1; 010 sign-extend low 8 bits; 011 zero-extend low 8 bits; 100 constant << 8, truncated to LARGURA; 101–111 output 0.
- Pipeline register priority per edge: reset > flush > stall > load.
  - reset: a, b, constante_extendida, copia_pc, all bank entries = 0; out_valido = 0.
  - flush: out_valido = 0; data outputs don't care (hold).
  - stall: all outputs hold (except bypass refresh, below).
  - load: a/b = bank[sel_a]/bank[sel_b] (bypassed if enabled), constante_extendida = extender result, out_valido = in_valido; sel_a/sel_b latched internally.
- Bank writes and copia_pc updates are independent of stall/flush.

## Timing
- Read latency: 1 cycle (inputs at edge N → outputs valid after edge N).
- Write latency: written value is visible in the bank after the write edge; without bypass a read of the same address in the write cycle returns the old value.
- Reset mid-operation: next edge clears everything; out_valido low the following cycle; no write-back on the reset edge.
- flush and stall together: flush wins, out_valido=0.

## Configuration
- ID_RF_BYPASS_EN defined: during load, if a write is performed this cycle and sel_escrita equals sel_a (sel_b), a (b) captures the write data instead of the bank value. While stalled, if a write hits a latched sel_a/sel_b, the held a/b is refreshed with the write data; out_valido is unchanged.
- Not defined: no forwarding; a/b capture pre-write bank contents; held outputs are never refreshed.

## Test plan
- Reset: drive reset 1 cycle with junk inputs → a=b=constante_extendida=copia_pc=0, out_valido=0; reading all 8 registers returns 0.
- Write/read: write 0x1234 (ULA) to r3, next cycle sel_a=3, in_valido=1 → a=0x1234, out_valido=1 one edge later; controle_resu=3 with hab_escrita=1 leaves r3 unchanged.
- Extender: ex_constante=0x8F0 with modes 000/001/010/011/100/111 → 0x08F0, 0xF8F0, 0xFFF0, 0x00F0, 0xF000, 0x0000.
- PC copy/link: pc=0x0040, controle_pc_copia=1; next cycle controle_resu=2 to r7 → r7=0x0040; simultaneous pc capture and write writes prior copia_pc.
- Stall/flush: load r1=0x0011 into a, raise stall 3 cycles while changing sel_a → a holds 0x0011; flush+stall → out_valido=0.
- Bypass (both builds): same-cycle write 0xBEEF to r2 with sel_b=2 → b=0xBEEF with ID_RF_BYPASS_EN, old r2 without; write to latched sel_b during stall refreshes b only with macro.

Source files
------------

// File: rtl/id_rf_pipe.sv
// id_rf_pipe: decode / register-fetch stage.
// Holds the register bank, the write-back source mux, the PC-copy (link)
// register and the constant extender. Operands A, B and the extended constant
// are registered into an ID/EX pipeline register with valid, stall and flush.
// Optional feature macro: ID_RF_BYPASS_EN (write-to-read forwarding). When it
// is undefined the operands capture the bank contents as they were before the
// write edge.
module id_rf_pipe #(
    parameter int LARGURA       = 16,
    parameter int NUM_REG       = 8,
    parameter int LARGURA_CONST = 12,
    localparam int AW           = $clog2(NUM_REG)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valido,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     hab_escrita,
    input  logic [AW-1:0]            sel_escrita,
    input  logic [AW-1:0]            sel_a,
    input  logic [AW-1:0]            sel_b,
    input  logic [1:0]               controle_resu,
    input  logic [LARGURA-1:0]       entrada_ula,
    input  logic [LARGURA-1:0]       entrada_md,
    input  logic [LARGURA-1:0]       pc,
    input  logic                     controle_pc_copia,
    input  logic [2:0]               ex_controle,
    input  logic [LARGURA_CONST-1:0] ex_constante,
    output logic [LARGURA-1:0]       a,
    output logic [LARGURA-1:0]       b,
    output logic [LARGURA-1:0]       constante_extendida,
    output logic                     out_valido,
    output logic [LARGURA-1:0]       copia_pc
);

    // Constant extender; unused modes produce zero.
    function automatic logic [LARGURA-1:0] estende(
        input logic [2:0]               modo,
        input logic [LARGURA_CONST-1:0] k
    );
        logic [LARGURA-1:0] zext;
        logic [LARGURA-1:0] res;
        zext = LARGURA'(k);
        case (modo)
            3'b000:  res = zext;
            3'b001:  res = LARGURA'(signed'(k));
            3'b010:  res = LARGURA'(signed'(k[7:0]));
            3'b011:  res = LARGURA'(k[7:0]);
            3'b100:  res = zext << 4'd8;
            default: res = {LARGURA{1'b0}};
        endcase
        return res;
    endfunction

    logic [LARGURA-1:0] bank_r [NUM_REG];
    logic [LARGURA-1:0] copia_pc_r;
    logic [LARGURA-1:0] a_r;
    logic [LARGURA-1:0] b_r;
    logic [LARGURA-1:0] const_r;
    logic               valido_r;

    logic               we_s;
    logic [LARGURA-1:0] wdata_s;
    logic [LARGURA-1:0] rd_a_s;
    logic [LARGURA-1:0] rd_b_s;
    logic [LARGURA-1:0] ext_s;

    // Write-back source select and write enable (source 3 means no write).
    always_comb begin
        we_s = hab_escrita && (controle_resu != 2'd3);
        case (controle_resu)
            2'd0:    wdata_s = entrada_ula;
            2'd1:    wdata_s = entrada_md;
            2'd2:    wdata_s = copia_pc_r;
            default: wdata_s = {LARGURA{1'b0}};
        endcase
    end

`ifdef ID_RF_BYPASS_EN
    logic [AW-1:0] sel_a_lat_r;
    logic [AW-1:0] sel_b_lat_r;

    // Read ports with forwarding of the write performed in this same cycle.
    always_comb begin
        if (we_s && (sel_escrita == sel_a)) begin
            rd_a_s = wdata_s;
        end else begin
            rd_a_s = bank_r[sel_a];
        end
        if (we_s && (sel_escrita == sel_b)) begin
            rd_b_s = wdata_s;
        end else begin
            rd_b_s = bank_r[sel_b];
        end
        ext_s = estende(ex_controle, ex_constante);
    end

    // ID/EX pipeline register: reset > flush > stall (with refresh) > load.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_r         <= {LARGURA{1'b0}};
            b_r         <= {LARGURA{1'b0}};
            const_r     <= {LARGURA{1'b0}};
            valido_r    <= 1'b0;
            sel_a_lat_r <= {AW{1'b0}};
            sel_b_lat_r <= {AW{1'b0}};
        end else if (flush) begin
            valido_r <= 1'b0;
        end else if (stall) begin
            if (we_s && (sel_escrita == sel_a_lat_r)) begin
                a_r <= wdata_s;
            end
            if (we_s && (sel_escrita == sel_b_lat_r)) begin
                b_r <= wdata_s;
            end
        end else begin
            a_r         <= rd_a_s;
            b_r         <= rd_b_s;
            const_r     <= ext_s;
            valido_r    <= in_valido;
            sel_a_lat_r <= sel_a;
            sel_b_lat_r <= sel_b;
        end
    end
`else
    // Plain asynchronous read ports: pre-write bank contents.
    always_comb begin
        rd_a_s = bank_r[sel_a];
        rd_b_s = bank_r[sel_b];
        ext_s  = estende(ex_controle, ex_constante);
    end

    // ID/EX pipeline register: reset > flush > stall > load.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_r      <= {LARGURA{1'b0}};
            b_r      <= {LARGURA{1'b0}};
            const_r  <= {LARGURA{1'b0}};
            valido_r <= 1'b0;
        end else if (flush) begin
            valido_r <= 1'b0;
        end else if (stall) begin
            valido_r <= valido_r;
        end else begin
            a_r      <= rd_a_s;
            b_r      <= rd_b_s;
            const_r  <= ext_s;
            valido_r <= in_valido;
        end
    end
`endif

    // Register bank write port; independent of stall and flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REG; i++) begin
                bank_r[i] <= {LARGURA{1'b0}};
            end
        end else if (we_s) begin
            bank_r[sel_escrita] <= wdata_s;
        end
    end

    // Link register: captures pc on request, otherwise holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            copia_pc_r <= {LARGURA{1'b0}};
        end else if (controle_pc_copia) begin
            copia_pc_r <= pc;
        end
    end

    assign a                   = a_r;
    assign b                   = b_r;
    assign constante_extendida = const_r;
    assign out_valido          = valido_r;
    assign copia_pc            = copia_pc_r;

endmodule

// File: tb/tb_id_rf_pipe.sv
// Scoreboard bench for id_rf_pipe: stimulus pushes expected operand triples,
// a monitor pops one whenever out_valido is seen high.
module tb_id_rf_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valido;
    logic        stall;
    logic        flush;
    logic        hab_escrita;
    logic [2:0]  sel_escrita;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
    logic [1:0]  controle_resu;
    logic [15:0] entrada_ula;
    logic [15:0] entrada_md;
    logic [15:0] pc;
    logic        controle_pc_copia;
    logic [2:0]  ex_controle;
    logic [11:0] ex_constante;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] constante_extendida;
    logic        out_valido;
    logic [15:0] copia_pc;

    typedef struct packed {
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef ID_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    id_rf_pipe #(.LARGURA(16), .NUM_REG(8), .LARGURA_CONST(12)) dut (
        .clock(clock), .reset(reset), .in_valido(in_valido), .stall(stall),
        .flush(flush), .hab_escrita(hab_escrita), .sel_escrita(sel_escrita),
        .sel_a(sel_a), .sel_b(sel_b), .controle_resu(controle_resu),
        .entrada_ula(entrada_ula), .entrada_md(entrada_md), .pc(pc),
        .controle_pc_copia(controle_pc_copia), .ex_controle(ex_controle),
        .ex_constante(ex_constante), .a(a), .b(b),
        .constante_extendida(constante_extendida), .out_valido(out_valido),
        .copia_pc(copia_pc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents valid operands.
    always @(negedge clock) begin
        exp_t e;
        if (out_valido === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%h/%h/%h required=none", a, b, constante_extendida);
            end else begin
                e = exp_q.pop_front();
                chk("op_a", a, e.ea);
                chk("op_b", b, e.eb);
                chk("const", constante_extendida, e.ec);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; in_valido = 1'b0; stall = 1'b0; flush = 1'b0;
        hab_escrita = 1'b0; sel_escrita = 3'd0; sel_a = 3'd0; sel_b = 3'd0;
        controle_resu = 2'd0; entrada_ula = 16'h0000; entrada_md = 16'h0000;
        pc = 16'h0000; controle_pc_copia = 1'b0; ex_controle = 3'b000;
        ex_constante = 12'h000;
    endtask

    logic [2:0]  modes [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    logic [15:0] ext_exp [6] = '{16'h08F0, 16'hF8F0, 16'hFFF0, 16'h00F0, 16'hF000, 16'h0000};

    initial begin
        logic [15:0] b_prev;
        idle_inputs();
        // Reset with junk inputs
        reset = 1'b1; in_valido = 1'b1; hab_escrita = 1'b1; sel_escrita = 3'd5;
        entrada_ula = 16'hFFFF; pc = 16'hABCD; controle_pc_copia = 1'b1;
        ex_constante = 12'hFFF; sel_a = 3'd5;
        cyc();
        idle_inputs();
        chk("rst_a", a, 16'h0000);
        chk("rst_b", b, 16'h0000);
        chk("rst_const", constante_extendida, 16'h0000);
        chk("rst_copia_pc", copia_pc, 16'h0000);
        chk("rst_valid", {15'd0, out_valido}, 16'h0000);

        // All registers read zero after reset
        for (int i = 0; i < 8; i++) begin
            sel_a = 3'(i); sel_b = 3'(7 - i); in_valido = 1'b1;
            exp_q.push_back('{16'h0000, 16'h0000, 16'h0000});
            cyc();
        end
        in_valido = 1'b0;

        // Write 0x1234 to r3 via ULA, then read it
        hab_escrita = 1'b1; controle_resu = 2'd0; sel_escrita = 3'd3; entrada_ula = 16'h1234;
        cyc();
        hab_escrita = 1'b0; sel_a = 3'd3; sel_b = 3'd0; in_valido = 1'b1;
        exp_q.push_back('{16'h1234, 16'h0000, 16'h0000});
        cyc();
        in_valido = 1'b0;

        // Source 3 suppresses the write even with hab_escrita
        hab_escrita = 1'b1; controle_resu = 2'd3; sel_escrita = 3'd3; entrada_ula = 16'h5555;
        cyc();
        hab_escrita = 1'b0; controle_resu = 2'd0; sel_a = 3'd3; in_valido = 1'b1;
        exp_q.push_back('{16'h1234, 16'h0000, 16'h0000});
        cyc();

        // Extender modes
        sel_a = 3'd0; ex_constante = 12'h8F0;
        for (int i = 0; i < 6; i++) begin
            ex_controle = modes[i];
            exp_q.push_back('{16'h0000, 16'h0000, ext_exp[i]});
            cyc();
        end
        in_valido = 1'b0; ex_controle = 3'b000; ex_constante = 12'h000;

        // PC copy and link write
        pc = 16'h0040; controle_pc_copia = 1'b1;
        cyc();
        chk("copia_pc_load", copia_pc, 16'h0040);
        controle_pc_copia = 1'b0; hab_escrita = 1'b1; controle_resu = 2'd2; sel_escrita = 3'd7;
        cyc();
        hab_escrita = 1'b0; controle_resu = 2'd0; sel_a = 3'd7; in_valido = 1'b1;
        exp_q.push_back('{16'h0040, 16'h0000, 16'h0000});
        cyc();
        in_valido = 1'b0;
        // Simultaneous capture and link write: r6 gets the old copy
        pc = 16'h0080; controle_pc_copia = 1'b1; hab_escrita = 1'b1;
        controle_resu = 2'd2; sel_escrita = 3'd6;
        cyc();
        chk("copia_pc_new", copia_pc, 16'h0080);
        controle_pc_copia = 1'b0; hab_escrita = 1'b0; controle_resu = 2'd0;
        sel_a = 3'd6; sel_b = 3'd7; in_valido = 1'b1;
        exp_q.push_back('{16'h0040, 16'h0040, 16'h0000});
        cyc();
        in_valido = 1'b0; sel_b = 3'd0;

        // Stall holds, then flush+stall clears valid
        hab_escrita = 1'b1; sel_escrita = 3'd1; entrada_ula = 16'h0011;
        cyc();
        hab_escrita = 1'b0; sel_a = 3'd1; in_valido = 1'b1;
        exp_q.push_back('{16'h0011, 16'h0000, 16'h0000});
        cyc();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel_a = (i == 0) ? 3'd3 : ((i == 1) ? 3'd6 : 3'd7);
            exp_q.push_back('{16'h0011, 16'h0000, 16'h0000});
            cyc();
        end
        flush = 1'b1;
        cyc();
        chk("flush_valid", {15'd0, out_valido}, 16'h0000);
        stall = 1'b0; flush = 1'b0; in_valido = 1'b0;

        // Same-cycle write to r2 while reading it on port B
        sel_a = 3'd0; sel_b = 3'd2; in_valido = 1'b1; hab_escrita = 1'b1;
        controle_resu = 2'd0; sel_escrita = 3'd2; entrada_ula = 16'hBEEF;
        b_prev = BYP ? 16'hBEEF : 16'h0000;
        exp_q.push_back('{16'h0000, b_prev, 16'h0000});
        cyc();
        // Write to latched sel_b during stall
        stall = 1'b1; sel_b = 3'd5; entrada_ula = 16'hCAFE;
        exp_q.push_back('{16'h0000, BYP ? 16'hCAFE : b_prev, 16'h0000});
        cyc();
        stall = 1'b0; hab_escrita = 1'b0; sel_b = 3'd2;
        exp_q.push_back('{16'h0000, 16'hCAFE, 16'h0000});
        cyc();
        in_valido = 1'b0;

        // Reset mid-operation: write on the reset edge is dropped
        reset = 1'b1; in_valido = 1'b1; hab_escrita = 1'b1; sel_escrita = 3'd4;
        entrada_ula = 16'h7777;
        cyc();
        reset = 1'b0; hab_escrita = 1'b0;
        chk("rst2_valid", {15'd0, out_valido}, 16'h0000);
        chk("rst2_copia_pc", copia_pc, 16'h0000);
        sel_a = 3'd3; sel_b = 3'd4;
        exp_q.push_back('{16'h0000, 16'h0000, 16'h0000});
        cyc();
        in_valido = 1'b0;
        cyc();
        cyc();
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
